// File: rtl/fifo_rdport.sv
// rtl/fifo_rdport.sv - FIFO read-domain port: Gray read pointer, empty flag, registered output word; optional rd_aempty under RD_AEMPTY_EN
module fifo_rdport #(
   parameter int DATASIZE      = 8,
   parameter int ADDRSIZE      = 4,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   input  logic [DATASIZE-1:0] rdata_mem,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic [DATASIZE-1:0] dout,
   output logic                dout_valid,
   input  logic                dout_ready
`ifdef RD_AEMPTY_EN
   ,
   output logic                rd_aempty
`endif
);

   // A threshold outside 0..depth can never be a meaningful level comparison.
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDRSIZE)) begin : g_thresh_check
      $error("fifo_rdport: AEMPTY_THRESH out of range");
   end

   logic [ADDRSIZE:0] rbin;
   logic [ADDRSIZE:0] rbinnext;
   logic [ADDRSIZE:0] rgraynext;
   logic              fetch;

   assign raddr = rbin[ADDRSIZE-1:0];

   // Fetch when a word is available and the output register is free or being drained this cycle.
   always_comb begin
      fetch     = !rempty && (!dout_valid || dout_ready);
      rbinnext  = rbin + {{ADDRSIZE{1'b0}}, fetch};
      rgraynext = (rbinnext >> 1) ^ rbinnext;
   end

   // Read pointer and empty flag; compare in Gray so the wrap from all-ones to zero is glitch-free.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin   <= '0;
         rptr   <= '0;
         rempty <= 1'b1;
      end else begin
         rbin   <= rbinnext;
         rptr   <= rgraynext;
         rempty <= (rgraynext == rq2_wptr);
      end
   end

   // Output register: load on fetch, clear valid when consumed without a refill, otherwise hold.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (fetch) begin
         dout       <= rdata_mem;
         dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

`ifdef RD_AEMPTY_EN
   localparam logic [31:0] THRESH = 32'(AEMPTY_THRESH);

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] level;

   // Gray-to-binary of the synchronized write pointer, then words left after this cycle's fetch.
   always_comb begin
      wbin = '0;
      for (int i = 0; i <= ADDRSIZE; i++) begin
         wbin[i] = ^(rq2_wptr >> i);
      end
      level = wbin - rbinnext;
   end

   // Almost-empty registered alongside rempty so both flags move on the same edge.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rd_aempty <= 1'b1;
      end else begin
         rd_aempty <= ({{(31-ADDRSIZE){1'b0}}, level} <= THRESH);
      end
   end
`endif

endmodule

// File: doc/fifo_rdport.md
FIFO_RDPORT -- requirements
Module: fifo_rdport

Interface
REQ-001 SHALL provide parameter DATASIZE, default 8: width in bits of each FIFO word.
REQ-002 SHALL provide parameter ADDRSIZE, default 4: memory address width; depth is 2^ADDRSIZE.
REQ-003 SHALL provide parameter AEMPTY_THRESH, default 2: almost-empty level threshold; used only when RD_AEMPTY_EN is defined.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: rclk  input  1  read-domain clock; rrst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port rq2_wptr  input  ADDRSIZE+1  Gray-coded write pointer, already synchronized into rclk.
REQ-006 SHALL have port rdata_mem  input  DATASIZE  combinational read data returned by the memory for raddr.
REQ-007 SHALL have port raddr  output  ADDRSIZE  memory read address.
REQ-008 SHALL have port rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain.
REQ-009 SHALL have port rempty  output  1  registered FIFO-empty flag.
REQ-010 SHALL have port dout  output  DATASIZE  registered output word.
REQ-011 SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-012 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-013 SHALL have port rd_aempty  output  1  almost-empty flag; present only when RD_AEMPTY_EN is defined.

Function
REQ-014 SHALL keep binary read counter rbin (ADDRSIZE+1 bits) and drive raddr = rbin[ADDRSIZE-1:0].
REQ-015 SHALL define fetch = !rempty && (!dout_valid || dout_ready), evaluated combinationally each cycle.
REQ-016 On fetch, SHALL at the next rclk edge load dout <= rdata_mem, set dout_valid = 1, and set rbin = rbin+1.
REQ-017 Without fetch, dout_valid && dout_ready SHALL clear dout_valid at the next edge, and dout SHALL hold its value.
REQ-018 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-019 rbinnext SHALL be rbin+fetch; rgraynext SHALL be (rbinnext>>1)^rbinnext; rptr SHALL register rgraynext.
REQ-020 rempty SHALL register (rgraynext == rq2_wptr).
REQ-021 rbin SHALL wrap modulo 2^(ADDRSIZE+1), from all-ones to zero, with no glitch in empty detection across the wrap.
REQ-022 Latency: a cycle in which rq2_wptr first differs from rptr SHALL produce rempty=0 after one edge and dout_valid=1 after two edges.
REQ-023 With data continuously available and dout_ready=1, throughput SHALL be one word per cycle (simultaneous consume and fetch).
REQ-024 rptr SHALL change by at most one Gray bit per cycle.

Reset
REQ-025 rrst=1 SHALL asynchronously force rbin=0, rptr=0, rempty=1, dout=0, dout_valid=0, and rd_aempty=1 when that port is present.
REQ-026 Reset asserted mid-operation SHALL discard any word held in dout; after release, operation SHALL resume from address 0.
REQ-027 No fetch SHALL occur in the first edge after reset release, because rempty=1.

Configuration
REQ-028 Macro RD_AEMPTY_EN, when defined, SHALL add rd_aempty, computed as follows:
- Convert rq2_wptr to binary wbin.
- Compute level = (wbin - rbinnext) mod 2^(ADDRSIZE+1).
- Register rd_aempty <= (level <= AEMPTY_THRESH).
REQ-029 When RD_AEMPTY_EN is undefined, port rd_aempty and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (ADDRSIZE=4, DATASIZE=8)
REQ-030 Reset, then rq2_wptr=0 held -> rempty=1, dout_valid=0, raddr=0, rptr=0 indefinitely.
REQ-031 mem[0]=0xA5, rq2_wptr 0->1 with dout_ready=0 -> rempty=0 one edge later, dout=0xA5 with dout_valid=1 the next edge; dout holds and rptr=1 (Gray), rempty=1.
REQ-032 16 words written, rq2_wptr=Gray(16)=0x18, dout_ready=1 -> 16 consecutive dout_valid cycles, data in address order 0..15, then rempty=1 with rptr=0x18.
REQ-033 Stream 40 words with random dout_ready back-pressure -> no loss or duplication, in-order data, rbin wraps 31->0, and every rptr step is a one-bit change.
REQ-034 Assert rrst while dout_valid=1 and rbin=7 -> all outputs take reset values immediately; after release, reads restart at raddr=0.
REQ-035 RD_AEMPTY_EN, AEMPTY_THRESH=2: level sequence 5, 3, 2, 0 -> rd_aempty = 0, 0, 1, 1.
